// File: rtl/rvscc_div_pkg.sv
// Shared types and helpers for the iterative RV32M divider.
package rvscc_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic is_signed(div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic wants_rem(div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift, trial subtract, conditional restore.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           qbit;

    // quo carries the remaining dividend bits in its top, quotient bits enter at the bottom
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, div};
        qbit     = ~diff[WIDTH];
        rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], qbit};
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// RVSCC_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration.
module iter_divider
    import rvscc_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    div_op_e          op_q;
    logic             q_neg_q, r_neg_q, spec_q;
    logic [WIDTH-1:0] rem_q, quo_q, div_q, spec_val_q;
    logic [CW-1:0]    count_q;

    div_op_e          op_c;
    logic             sgn_c, a_neg_c, b_neg_c, b_zero_c, ovf_c, spec_c, accept_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c, spec_val_c;
    logic [WIDTH-1:0] rem_n, quo_n, q_fix_c, r_fix_c, final_c;

    // Operand conditioning and special-case detection at acceptance
    always_comb begin
        op_c       = div_op_e'(op);
        sgn_c      = is_signed(op_c);
        a_neg_c    = sgn_c & a[WIDTH-1];
        b_neg_c    = sgn_c & b[WIDTH-1];
        a_mag_c    = a_neg_c ? WIDTH'(-a) : a;
        b_mag_c    = b_neg_c ? WIDTH'(-b) : b;
        b_zero_c   = (b == '0);
        ovf_c      = sgn_c && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        spec_c     = b_zero_c | ovf_c;
        if (b_zero_c)
            spec_val_c = wants_rem(op_c) ? a : '1;
        else
            spec_val_c = wants_rem(op_c) ? '0 : a;
        accept_c   = req_valid && req_ready;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .div      (div_q),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    // Sign correction of the final step's magnitudes
    always_comb begin
        q_fix_c = q_neg_q ? WIDTH'(-quo_n) : quo_n;
        r_fix_c = r_neg_q ? WIDTH'(-rem_n) : rem_n;
        if (spec_q)
            final_c = spec_val_q;
        else
            final_c = wants_rem(op_q) ? r_fix_c : q_fix_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = CALC;
`ifdef RVSCC_DIV_EARLY_OUT_EN
                    if (spec_c)
                        state_d = DONE;
`endif
                end
            end
            CALC: if (count_q == CW'(1)) state_d = DONE;
            DONE: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs registered from the next state so they track state_q exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            req_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= DIV;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            count_q    <= '0;
            result     <= '0;
        end else if (state_q == IDLE) begin
            if (accept_c) begin
                op_q       <= op_c;
                q_neg_q    <= a_neg_c ^ b_neg_c;
                r_neg_q    <= a_neg_c;
                spec_q     <= spec_c;
                spec_val_q <= spec_val_c;
                rem_q      <= '0;
                quo_q      <= a_mag_c;
                div_q      <= b_mag_c;
                count_q    <= CW'(WIDTH);
`ifdef RVSCC_DIV_EARLY_OUT_EN
                if (spec_c)
                    result <= spec_val_c;
`endif
            end
        end else if (state_q == CALC) begin
            rem_q   <= rem_n;
            quo_q   <= quo_n;
            count_q <= count_q - CW'(1);
            if (count_q == CW'(1))
                result <= final_c;
        end
    end

endmodule
